rangefinder_sample_capture: RTL and testbench

RANGEFINDER_SAMPLE_CAPTURE -- requirements
Module: rangefinder_sample_capture

---
 rtl/rangefinder_sample_capture.sv | 172 +++++++++++++++++
 tb/tb_rangefinder_sample_capture.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rangefinder_sample_capture.sv
// Purpose: arms on start, waits for a fresh laser trigger edge, then decimates ADC samples into a sample RAM.
// Latency: a kept sample at cycle N is written at cycle N+1; done/done_irq follow the final write by one cycle.
// Backpressure: none; the RAM write port is always ready, and adc_valid=0 cycles simply pause the capture.
module rangefinder_sample_capture #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] adc_data,
    input  logic          adc_valid,
    input  logic          trig,
    input  logic          start,
    input  logic          abort,
    input  logic [AW:0]   sample_count,
    input  logic [3:0]    decim,
    output logic [AW-1:0] address2,
    output logic [DW-1:0] writedata2,
    output logic          write2,
    output logic          chipselect2,
    output logic          busy,
    output logic          done,
    output logic          done_irq,
    output logic [AW:0]   wr_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Full RAM size expressed in the sample-count width (AW+1 bits holds DEPTH itself).
    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

    state_t        r_state;
    logic          r_trig_prev;
    logic [AW:0]   r_count;
    logic [3:0]    r_decim;
    logic [3:0]    r_decim_cnt;
    logic [AW:0]   r_wr_count;
    logic [AW-1:0] r_address2;
    logic [DW-1:0] r_writedata2;
    logic          r_write2;
    logic          r_busy;
    logic          r_done;
    logic          r_done_irq;

    logic          w_trig_edge;
    logic          w_start_ok;
    logic          w_trig_arm;
    logic          w_cap_valid;
    logic          w_keep;
    logic          w_last_write;
    logic [AW:0]   w_count_norm;

    // A zero or oversized request means "fill the whole RAM".
    assign w_count_norm = ((sample_count == '0) || (sample_count > LP_DEPTH)) ? LP_DEPTH : sample_count;

    // Only a 0->1 transition counts; a trigger already high at arming is ignored.
    assign w_trig_edge  = trig & ~r_trig_prev;

    // Abort has priority over every other event, including a coincident start.
    assign w_start_ok   = start & ~abort & ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_trig_arm   = (r_state == S_ARM) & w_trig_edge & ~abort;

    // A valid sample that still has room in this capture; only these advance the decimator.
    assign w_cap_valid  = (r_state == S_CAPTURE) & adc_valid & ~abort & (r_wr_count < r_count);
    assign w_keep       = w_cap_valid & (r_decim_cnt == 4'd0);

    // wr_count already includes the write presented this cycle, so equality marks the final write.
    assign w_last_write = (r_state == S_CAPTURE) & r_write2 & (r_wr_count == r_count);

    // Trigger history for edge detection; runs in every state so arming sees the true prior level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_trig_prev <= 1'b0;
        end else begin
            r_trig_prev <= trig;
        end
    end

    // Capture control FSM with registered status outputs and the per-capture parameter latches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_done_irq <= 1'b0;
            r_count    <= '0;
            r_decim    <= '0;
        end else begin
            r_done_irq <= 1'b0;
            if (abort) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (w_start_ok) begin
                            r_state <= S_ARM;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                            r_count <= w_count_norm;
                            r_decim <= decim;
                        end
                    end
                    S_ARM: begin
                        if (w_trig_arm) begin
                            r_state <= S_CAPTURE;
                        end
                    end
                    S_CAPTURE: begin
                        if (w_last_write) begin
                            r_state    <= S_DONE;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_done_irq <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Decimation counter: cleared by the trigger so the first valid sample is always kept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_decim_cnt <= '0;
        end else if (w_trig_arm) begin
            r_decim_cnt <= '0;
        end else if (w_cap_valid) begin
            r_decim_cnt <= (r_decim_cnt == 4'd0) ? r_decim : (r_decim_cnt - 4'd1);
        end
    end

    // RAM write path: register the kept sample and its index; wr_count counts alongside the strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write2     <= 1'b0;
            r_writedata2 <= '0;
            r_address2   <= '0;
            r_wr_count   <= '0;
        end else begin
            r_write2 <= w_keep;
            if (w_keep) begin
                r_writedata2 <= adc_data;
                r_address2   <= r_wr_count[AW-1:0];
                r_wr_count   <= r_wr_count + 1'b1;
            end else if (w_start_ok) begin
                r_wr_count   <= '0;
            end
        end
    end

    assign address2    = r_address2;
    assign writedata2  = r_writedata2;
    assign write2      = r_write2;
    assign chipselect2 = r_write2;
    assign busy        = r_busy;
    assign done        = r_done;
    assign done_irq    = r_done_irq;
    assign wr_count    = r_wr_count;

endmodule

// File: tb/tb_rangefinder_sample_capture.sv
// Scoreboard bench for rangefinder_sample_capture: directed captures push expected RAM writes
// and completion cycles into queues; a negedge monitor pops and compares whenever the DUT writes
// or raises done_irq, and any write or completion with nothing queued is reported.
module tb_rangefinder_sample_capture;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] adc_data = '0;
    logic          adc_valid = 1'b0;
    logic          trig = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW:0]   sample_count = '0;
    logic [3:0]    decim = '0;
    logic [AW-1:0] address2;
    logic [DW-1:0] writedata2;
    logic          write2;
    logic          chipselect2;
    logic          busy;
    logic          done;
    logic          done_irq;
    logic [AW:0]   wr_count;

    rangefinder_sample_capture #(.DEPTH(256), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .adc_data     (adc_data),
        .adc_valid    (adc_valid),
        .trig         (trig),
        .start        (start),
        .abort        (abort),
        .sample_count (sample_count),
        .decim        (decim),
        .address2     (address2),
        .writedata2   (writedata2),
        .write2       (write2),
        .chipselect2  (chipselect2),
        .busy         (busy),
        .done         (done),
        .done_irq     (done_irq),
        .wr_count     (wr_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [AW:0]   cnt;
        int            cyc;
    } wr_exp_t;

    wr_exp_t wr_q[$];
    int      done_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every RAM write and every completion pulse against the queued expectations.
    always @(negedge clk) begin
        wr_exp_t e;
        int      dc;
        if (write2) begin
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h, required no write (cycle %0d)",
                         address2, writedata2, cyc);
            end else begin
                e = wr_q.pop_front();
                chk("wr_addr", 32'(address2), 32'(e.addr));
                chk("wr_data", 32'(writedata2), 32'(e.data));
                chk("wr_cs", 32'(chipselect2), 32'd1);
                chk("wr_count_at_write", 32'(wr_count), 32'(e.cnt));
                chk("wr_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (chipselect2) begin
            chk("cs_without_write", 32'(chipselect2), 32'd0);
        end
        if (done_irq) begin
            if (done_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done_irq: got pulse, required none (cycle %0d)", cyc);
            end else begin
                dc = done_q.pop_front();
                chk("done_irq_cycle", 32'(cyc), 32'(dc));
                chk("done_with_irq", 32'(done), 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cap(input logic [AW:0] n, input logic [3:0] d);
        sample_count = n;
        decim        = d;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    // Low then high: the second edge sees a fresh 0->1 transition.
    task automatic fire();
        trig = 1'b0;
        tick();
        trig = 1'b1;
        tick();
        trig = 1'b0;
    endtask

    task automatic sample(input logic [DW-1:0] dat, input bit keep, input int idx);
        wr_exp_t e;
        adc_valid = 1'b1;
        adc_data  = dat;
        if (keep) begin
            e.addr = idx[AW-1:0];
            e.data = dat;
            e.cnt  = (AW+1)'(idx + 1);
            e.cyc  = cyc + 1;
            wr_q.push_back(e);
        end
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && !done; i++) tick();
        chk("done_reached", 32'(done), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_address2"}, 32'(address2), 32'd0);
        chk({tag, "_writedata2"}, 32'(writedata2), 32'd0);
        chk({tag, "_write2"}, 32'(write2), 32'd0);
        chk({tag, "_chipselect2"}, 32'(chipselect2), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_done_irq"}, 32'(done_irq), 32'd0);
        chk({tag, "_wr_count"}, 32'(wr_count), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at cycle %0d, required finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] d;

        // Reset state
        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b0;
        tick();

        // 4 samples, no decimation
        start_cap(9'd4, 4'd0);
        chk("arm_busy", 32'(busy), 32'd1);
        fire();
        for (int i = 0; i < 4; i++) sample(8'h10 + 8'(i), 1'b1, i);
        done_q.push_back(cyc + 1);
        wait_done();
        chk("t1_wr_count", 32'(wr_count), 32'd4);
        chk("t1_busy", 32'(busy), 32'd0);
        tick();
        chk("t1_irq_one_cycle", 32'(done_irq), 32'd0);
        chk("t1_done_sticky", 32'(done), 32'd1);

        // 3 samples, keep 1 of 3
        start_cap(9'd3, 4'd2);
        chk("t2_done_cleared", 32'(done), 32'd0);
        fire();
        for (int i = 0; i < 9; i++) begin
            sample(8'(i), (i % 3) == 0, i / 3);
            if (i == 6) done_q.push_back(cyc + 1);
        end
        wait_done();
        chk("t2_wr_count", 32'(wr_count), 32'd3);

        // count 0 means the whole RAM, no address wrap
        start_cap(9'd0, 4'd0);
        fire();
        for (int i = 0; i < 256; i++) begin
            d = 8'(i) ^ 8'h5A;
            sample(d, 1'b1, i);
        end
        done_q.push_back(cyc + 1);
        wait_done();
        chk("t3_wr_count", 32'(wr_count), 32'd256);
        for (int i = 0; i < 3; i++) sample(8'hFF, 1'b0, 0);
        chk("t3_done_sticky", 32'(done), 32'd1);

        // Trigger already high at arming must not start a capture
        trig = 1'b1;
        tick();
        start_cap(9'd2, 4'd0);
        for (int i = 0; i < 4; i++) sample(8'h77, 1'b0, 0);
        chk("t4_still_armed", 32'(busy), 32'd1);
        chk("t4_no_count", 32'(wr_count), 32'd0);
        chk("t4_not_done", 32'(done), 32'd0);
        fire();
        sample(8'hC1, 1'b1, 0);
        sample(8'hC2, 1'b1, 1);
        done_q.push_back(cyc + 1);
        wait_done();
        chk("t4_wr_count", 32'(wr_count), 32'd2);

        // Abort after 2 of 8 writes
        start_cap(9'd8, 4'd0);
        fire();
        sample(8'h21, 1'b1, 0);
        sample(8'h22, 1'b1, 1);
        abort     = 1'b1;
        adc_valid = 1'b1;
        adc_data  = 8'h23;
        tick();
        abort     = 1'b0;
        adc_valid = 1'b0;
        chk("t5_abort_busy", 32'(busy), 32'd0);
        chk("t5_abort_done", 32'(done), 32'd0);
        chk("t5_abort_wr_count", 32'(wr_count), 32'd2);
        for (int i = 0; i < 3; i++) sample(8'h24, 1'b0, 0);
        chk("t5_hold_wr_count", 32'(wr_count), 32'd2);
        // abort and start together: abort wins
        sample_count = 9'd4;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("t5_abort_start_busy", 32'(busy), 32'd0);
        fire();
        for (int i = 0; i < 3; i++) sample(8'h25, 1'b0, 0);
        chk("t5_still_idle", 32'(busy), 32'd0);

        // Reset after 5 writes
        start_cap(9'd8, 4'd0);
        fire();
        for (int i = 0; i < 5; i++) sample(8'h30 + 8'(i), 1'b1, i);
        tick();
        adc_valid = 1'b1;
        adc_data  = 8'hEE;
        #1;
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        trig = 1'b1;
        tick();
        trig = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            trig = ~trig;
            tick();
        end
        adc_valid = 1'b0;
        trig      = 1'b0;
        chk("t6_idle_busy", 32'(busy), 32'd0);
        chk("t6_idle_count", 32'(wr_count), 32'd0);
        start_cap(9'd3, 4'd0);
        fire();
        for (int i = 0; i < 3; i++) sample(8'hA0 + 8'(i), 1'b1, i);
        done_q.push_back(cyc + 1);
        wait_done();
        chk("t6_wr_count", 32'(wr_count), 32'd3);

        tick();
        tick();
        chk("writes_outstanding", 32'(wr_q.size()), 32'd0);
        chk("done_outstanding", 32'(done_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
